// File: rtl/rv32_pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline front end.
package rv32_pipeline_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: entries are allocated at issue, filled oldest-first
// as memory answers, and popped from the head once filled.
module fetch_buffer
  import rv32_pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          fill,
  input  logic [31:0]   fill_data,
  input  logic          pop,
  input  logic          clear,
  output logic [PW:0]   count,
  output logic          head_filled,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_instr,
  output logic          any_unfilled,
  output logic [PW:0]   num_unfilled
);

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] head_ptr, tail_ptr, fill_ptr;
  logic [PW:0]   count_q, unfilled_q;
  logic          alloc_ok, fill_ok, pop_ok;

  always_comb begin
    head_filled  = (count_q != '0) && entries[head_ptr].filled;
    head_pc      = entries[head_ptr].pc;
    head_instr   = entries[head_ptr].instr;
    any_unfilled = (unfilled_q != '0);
    num_unfilled = unfilled_q;
    count        = count_q;
    alloc_ok     = alloc && (count_q < FULL);
    fill_ok      = fill && any_unfilled;
    pop_ok       = pop && head_filled;
  end

  // Unfilled entries always sit contiguously between fill_ptr and tail_ptr,
  // so the oldest unfilled entry is simply fill_ptr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fill_ptr   <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
      end
    end else if (clear) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fill_ptr   <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      if (alloc_ok) begin
        entries[tail_ptr] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
        tail_ptr          <= tail_ptr + PW'(1);
      end
      if (fill_ok) begin
        entries[fill_ptr].instr  <= fill_data;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + PW'(1);
      end
      if (pop_ok) begin
        head_ptr <= head_ptr + PW'(1);
      end
      count_q    <= count_q + (PW+1)'(alloc_ok) - (PW+1)'(pop_ok);
      unfilled_q <= unfilled_q + (PW+1)'(alloc_ok) - (PW+1)'(fill_ok);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: PC, memory handshake, stale-response dropping
// after redirects, and the IF/ID register.
module fetch_stage
  import rv32_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  input  logic        stallD,
  input  logic        flushD,
  output logic        validD,
  output logic [31:0] instructionD,
  output logic [31:0] pcD
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0] pc_f;
  logic [PW:0] drop_count, drop_next;
  logic [PW:0] buf_count, num_unfilled;
  logic        head_filled, any_unfilled;
  logic [31:0] head_pc, head_instr;
  logic        issue, resp_drop, resp_fill, resp_used, pop;

  always_comb begin
    imemReqValid = !reset && !redirectValid && (buf_count < FULL);
    imemReqAddr  = pc_f;
    issue        = imemReqValid && imemReqReady;
    resp_drop    = imemRespValid && (drop_count != '0);
    resp_fill    = imemRespValid && (drop_count == '0);
    resp_used    = resp_drop || (resp_fill && any_unfilled);
    pop          = !redirectValid && !flushD && !stallD && head_filled;
    drop_next    = drop_count;
    // Every unfilled entry discarded by a redirect still owes a response;
    // a response landing in the redirect cycle settles one of them.
    if (redirectValid) begin
      drop_next = drop_count + num_unfilled - (PW+1)'(resp_used);
    end else if (resp_drop) begin
      drop_next = drop_count - (PW+1)'(1);
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .alloc        (issue),
    .alloc_pc     (pc_f),
    .fill         (resp_fill),
    .fill_data    (imemRespData),
    .pop          (pop),
    .clear        (redirectValid),
    .count        (buf_count),
    .head_filled  (head_filled),
    .head_pc      (head_pc),
    .head_instr   (head_instr),
    .any_unfilled (any_unfilled),
    .num_unfilled (num_unfilled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f         <= RESET_PC;
      drop_count   <= '0;
      validD       <= 1'b0;
      instructionD <= NOP_INSTR;
      pcD          <= '0;
    end else begin
      drop_count <= drop_next;
      if (redirectValid) begin
        pc_f   <= {redirectPc[31:2], 2'b00};
        validD <= 1'b0;
      end else begin
        if (issue) begin
          pc_f <= pc_f + 32'd4;
        end
        if (flushD) begin
          validD <= 1'b0;
        end else if (!stallD) begin
          validD <= head_filled;
          if (head_filled) begin
            instructionD <= head_instr;
            pcD          <= head_pc;
          end
        end
      end
    end
  end

endmodule
